sram_arbiter: RTL

Single-port SRAM arbiter that shares the encryption engine's one SRAM instance between two requesters: the Wishbone host path (key/plaintext load and result readback) and the compute engine path (controller-driven operand fetch and result writeback for encrypt/decrypt/add/multiply). It grants one access per cycle, using round-robin with an engine burst-lock and a starvation bound. It registers the winning command onto the SRAM port and routes read data back to the issuing requester through a tag pipeline matched to the SRAM read latency.

---
 rtl/sram_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Arbitrates one single-port SRAM between the host path and the compute engine,
// registering the winning command and steering read data back by owner tag.
module sram_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LAT     = 1,
  parameter int MAX_BURST  = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  input  logic                  eng_req,
  input  logic                  eng_we,
  input  logic [ADDR_WIDTH-1:0] eng_addr,
  input  logic [DATA_WIDTH-1:0] eng_wdata,
  input  logic                  eng_lock,
  output logic                  eng_gnt,
  output logic                  eng_rvalid,
  output logic [DATA_WIDTH-1:0] eng_rdata,
  output logic                  sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_wadr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  sram_ren,
  output logic [ADDR_WIDTH-1:0] sram_radr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  busy
);

  localparam int                CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic {OWN_HOST = 1'b0, OWN_ENG = 1'b1} owner_e;

  owner_e             last_winner;
  owner_e             issue_owner;
  logic               lock_active;
  logic [CNT_W-1:0]   burst_cnt;
  logic               host_win;
  logic               eng_win;
  logic               gnt_any;
  logic               sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [RD_LAT-1:0]  tag_v;
  logic [RD_LAT-1:0]  tag_eng;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    host_win = 1'b0;
    eng_win  = 1'b0;
    if (host_req && !eng_req) begin
      host_win = 1'b1;
    end else if (eng_req && !host_req) begin
      eng_win = 1'b1;
    end else if (host_req && eng_req) begin
      if (lock_active && burst_cnt < BURST_MAX)       eng_win  = 1'b1;
      else if (lock_active && burst_cnt == BURST_MAX) host_win = 1'b1;
      else if (last_winner == OWN_ENG)                host_win = 1'b1;
      else                                            eng_win  = 1'b1;
    end
  end

  // Grants are forced low while reset is held so nothing is accepted then.
  assign host_gnt  = host_win & ~wb_rst_i;
  assign eng_gnt   = eng_win  & ~wb_rst_i;
  assign gnt_any   = host_gnt | eng_gnt;
  assign sel_we    = host_gnt ? host_we    : eng_we;
  assign sel_addr  = host_gnt ? host_addr  : eng_addr;
  assign sel_wdata = host_gnt ? host_wdata : eng_wdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      last_winner <= OWN_ENG;
      issue_owner <= OWN_HOST;
      lock_active <= 1'b0;
      burst_cnt   <= '0;
      sram_wen    <= 1'b0;
      sram_ren    <= 1'b0;
      sram_wadr   <= '0;
      sram_radr   <= '0;
      sram_wdata  <= '0;
    end else begin
      if (host_gnt)     last_winner <= OWN_HOST;
      else if (eng_gnt) last_winner <= OWN_ENG;

      if (eng_gnt && eng_lock) begin
        lock_active <= 1'b1;
        if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + CNT_W'(1);
      end else begin
        lock_active <= 1'b0;
        burst_cnt   <= '0;
      end

      sram_wen <= gnt_any & sel_we;
      sram_ren <= gnt_any & ~sel_we;
      if (gnt_any) begin
        sram_wadr   <= sel_addr;
        sram_radr   <= sel_addr;
        sram_wdata  <= sel_wdata;
        issue_owner <= host_gnt ? OWN_HOST : OWN_ENG;
      end
    end
  end

  // NOTE: the tag pipeline is a handful of flops, not a memory, so it is reset to discard in-flight reads.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tag_v   <= '0;
      tag_eng <= '0;
    end else begin
      tag_v[0]   <= sram_ren;
      tag_eng[0] <= (issue_owner == OWN_ENG);
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_eng[i] <= tag_eng[i-1];
      end
    end
  end

  // Final tag stage lines up with the cycle the SRAM presents read data.
  assign host_rvalid = tag_v[RD_LAT-1] & ~tag_eng[RD_LAT-1];
  assign eng_rvalid  = tag_v[RD_LAT-1] &  tag_eng[RD_LAT-1];
  assign host_rdata  = wb_rst_i ? '0 : sram_rdata;
  assign eng_rdata   = wb_rst_i ? '0 : sram_rdata;
  assign busy        = |tag_v;

endmodule
